// File: rtl/sweep_learn_meas_pkg.sv
// Shared definitions for the learn-mode sweep: FSM encoding, amplitude width and the
// default sweep constants also used by the frequency stepper.
package sweep_learn_meas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_STORE,
        ST_STEP,
        ST_DONE
    } state_t;

    localparam int DEF_DW          = 10;
    localparam int DEF_N_STEPS     = 96;
    localparam int DEF_ADDR_W      = 7;
    localparam int FIRST_FREQ_WORD = 4;

    // One extra bit so that a full-scale peak-to-peak span cannot overflow.
    function automatic int amp_width(input int dw);
        return dw + 1;
    endfunction

endpackage

// File: rtl/sweep_amp_detect.sv
// Amplitude detector over a window of MEAS_SAMPLES valid samples: peak-to-peak by default,
// mean of |x| when AMP_MEAN_ABS_EN is defined. done_o flags the last sample of the window.
module sweep_amp_detect
    import sweep_learn_meas_pkg::*;
#(
    parameter int DW           = DEF_DW,
    parameter int MEAS_SAMPLES = 4096
) (
    input  logic          clk_50m,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          done_o,
    output logic [DW:0]   amp_o
);

    localparam int LOG2_N = $clog2(MEAS_SAMPLES);
    localparam int AMP_W  = amp_width(DW);
    localparam logic signed [DW-1:0] POS_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] NEG_MAX = {1'b1, {(DW-1){1'b0}}};

    logic signed [DW-1:0] sample;
    logic [LOG2_N-1:0]    cnt_q, cnt_d;

    assign sample = $signed(data_i);
    assign done_o = valid_i && !clear_i && (cnt_q == {LOG2_N{1'b1}});

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (valid_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef AMP_MEAN_ABS_EN
    localparam int ACC_W = DW + LOG2_N;

    logic [ACC_W-1:0] acc_q, acc_d;

    // The most negative code has no positive twin; clamp it to the largest magnitude.
    function automatic logic [DW-2:0] abs_sat(input logic signed [DW-1:0] x);
        logic signed [DW-1:0] neg;
        neg = -x;
        if (x == NEG_MAX) begin
            return POS_MAX[DW-2:0];
        end else if (x < 0) begin
            return neg[DW-2:0];
        end else begin
            return x[DW-2:0];
        end
    endfunction

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (valid_i) begin
            acc_d = acc_q + ACC_W'(abs_sat(sample));
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign amp_o = {1'b0, acc_q[ACC_W-1:LOG2_N]};
`else
    logic signed [DW-1:0] min_q, min_d;
    logic signed [DW-1:0] max_q, max_d;

    function automatic logic [AMP_W-1:0] span(input logic signed [DW-1:0] hi,
                                              input logic signed [DW-1:0] lo);
        logic signed [AMP_W-1:0] d;
        d = {hi[DW-1], hi} - {lo[DW-1], lo};
        return d[AMP_W-1] ? '0 : d;
    endfunction

    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (clear_i) begin
            min_d = POS_MAX;
            max_d = NEG_MAX;
        end else if (valid_i) begin
            if (sample < min_q) min_d = sample;
            if (sample > max_q) max_d = sample;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            min_q <= '0;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign amp_o = span(max_q, min_q);
`endif

endmodule

// File: rtl/sweep_learn_meas.sv
// Learn-mode receive sequencer: settle, measure amplitude, store one word per frequency step,
// pulse next_freq, repeat N_STEPS times. Define AMP_MEAN_ABS_EN for mean-|x| amplitude.
module sweep_learn_meas
    import sweep_learn_meas_pkg::*;
#(
    parameter int SETTLE_CYC   = 50000,
    parameter int MEAS_SAMPLES = 4096,
    parameter int N_STEPS      = DEF_N_STEPS,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DW           = DEF_DW,
    parameter int PULSE_CYC    = 4
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic              learn_en,
    input  logic              adc_valid,
    input  logic [DW-1:0]     adc_data,
    output logic              next_freq,
    output logic              amp_we,
    output logic [ADDR_W-1:0] amp_addr,
    output logic [DW:0]       amp_data,
    output logic              learn_busy,
    output logic              learn_done
);

    localparam int CNT_MAX = (SETTLE_CYC > PULSE_CYC) ? SETTLE_CYC : PULSE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  PULSE_LAST  = CNT_W'(PULSE_CYC - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST    = ADDR_W'(N_STEPS - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              learn_en_q;
    logic              learn_rise;
    logic              meas_clear;
    logic              meas_valid;
    logic              meas_done;
    logic [DW:0]       meas_amp;

    assign learn_rise = learn_en && !learn_en_q;
    assign meas_clear = (state_q == ST_SETTLE);
    assign meas_valid = adc_valid && (state_q == ST_MEASURE);

    sweep_amp_detect #(
        .DW          (DW),
        .MEAS_SAMPLES(MEAS_SAMPLES)
    ) u_amp_detect (
        .clk_50m(clk_50m),
        .rst    (rst),
        .clear_i(meas_clear),
        .valid_i(meas_valid),
        .data_i (adc_data),
        .done_o (meas_done),
        .amp_o  (meas_amp)
    );

    // learn_en_q resets high so a level held through reset is not mistaken for a new request.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            learn_en_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            learn_en_q <= learn_en;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        next_freq  = 1'b0;
        amp_we     = 1'b0;
        amp_addr   = '0;
        amp_data   = '0;
        learn_busy = 1'b0;
        learn_done = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (learn_rise) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                learn_busy = 1'b1;
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_MEASURE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_MEASURE: begin
                learn_busy = 1'b1;
                if (meas_done) state_d = ST_STORE;
            end
            ST_STORE: begin
                learn_busy = 1'b1;
                amp_we     = learn_en;
                amp_addr   = idx_q;
                amp_data   = meas_amp;
                cnt_d      = '0;
                state_d    = (idx_q == IDX_LAST) ? ST_DONE : ST_STEP;
            end
            ST_STEP: begin
                learn_busy = 1'b1;
                next_freq  = 1'b1;
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_SETTLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                learn_done = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Dropping learn_en abandons the sweep from anywhere, including DONE.
        if (state_q != ST_IDLE && !learn_en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end
    end

endmodule

// File: tb/tb_sweep_learn_meas.sv
// Directed-sequence bench with randomized ADC data, checked against a window model that
// takes the last MEAS_SAMPLES valid samples before each table write.
module tb_sweep_learn_meas;

    localparam int SETTLE_CYC   = 8;
    localparam int MEAS_SAMPLES = 16;
    localparam int N_STEPS      = 4;
    localparam int ADDR_W       = 2;
    localparam int DW           = 10;
    localparam int PULSE_CYC    = 4;

    logic              clk_50m = 1'b0;
    logic              rst;
    logic              learn_en;
    logic              adc_valid;
    logic [DW-1:0]     adc_data;
    logic              next_freq;
    logic              amp_we;
    logic [ADDR_W-1:0] amp_addr;
    logic [DW:0]       amp_data;
    logic              learn_busy;
    logic              learn_done;

    sweep_learn_meas #(
        .SETTLE_CYC  (SETTLE_CYC),
        .MEAS_SAMPLES(MEAS_SAMPLES),
        .N_STEPS     (N_STEPS),
        .ADDR_W      (ADDR_W),
        .DW          (DW),
        .PULSE_CYC   (PULSE_CYC)
    ) dut (
        .clk_50m   (clk_50m),
        .rst       (rst),
        .learn_en  (learn_en),
        .adc_valid (adc_valid),
        .adc_data  (adc_data),
        .next_freq (next_freq),
        .amp_we    (amp_we),
        .amp_addr  (amp_addr),
        .amp_data  (amp_data),
        .learn_busy(learn_busy),
        .learn_done(learn_done)
    );

    always #10 clk_50m = ~clk_50m;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    int hist[$];
    int sine_tab[16] = '{0, 115, 212, 277, 300, 277, 212, 115,
                         0, -115, -212, -277, -300, -277, -212, -115};
    int mode      = 0;
    int duty      = 1;
    int phase     = 0;
    int dcnt      = 0;
    int const_val = 0;

    int writes      = 0;
    int exp_addr    = 0;
    int pulses      = 0;
    int nf_run      = 0;
    int last_data   = 0;
    int rise_cyc    = 0;
    int nf_fall_cyc = 0;
    int first_lat   = -1;
    bit abort_cut   = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference amplitude of the most recent window of valid samples.
    function automatic int model_amp();
        int n, lo, hi, sum, a;
        n = hist.size();
        if (n < MEAS_SAMPLES) return -1;
        lo = 1 << 30;
        hi = -(1 << 30);
        sum = 0;
        for (int i = n - MEAS_SAMPLES; i < n; i++) begin
            if (hist[i] < lo) lo = hist[i];
            if (hist[i] > hi) hi = hist[i];
            a = (hist[i] < 0) ? -hist[i] : hist[i];
            if (a > 511) a = 511;
            sum += a;
        end
`ifdef AMP_MEAN_ABS_EN
        return sum / MEAS_SAMPLES;
`else
        return hi - lo;
`endif
    endfunction

    function automatic int gen_sample();
        int x;
        case (mode)
            1:       x = sine_tab[phase % 16];
            2:       x = (phase % 2 == 1) ? 511 : -512;
            3:       x = const_val;
            4:       x = (phase % 2 == 1) ? 100 : -100;
            default: x = int'($urandom_range(0, 1023)) - 512;
        endcase
        phase++;
        return x;
    endfunction

    // One clock: observe outputs on the falling edge, then drive the next inputs.
    task automatic step();
        int x;
        int min_gap;
        @(negedge clk_50m);
        cycle++;
        if (amp_we) begin
            chk("amp_addr", int'(amp_addr), exp_addr);
            chk("amp_data", int'(amp_data), model_amp());
            if (exp_addr == 0) begin
                first_lat = cycle - rise_cyc;
            end else begin
                min_gap = SETTLE_CYC + 1 + (MEAS_SAMPLES - 1) * duty;
                chk("window_gap", int'((cycle - nf_fall_cyc) >= min_gap), 1);
            end
            last_data = int'(amp_data);
            writes++;
            exp_addr++;
        end
        if (next_freq) begin
            nf_run++;
        end else if (nf_run > 0) begin
            if (!abort_cut) chk("next_freq_len", nf_run, PULSE_CYC);
            pulses++;
            nf_run      = 0;
            nf_fall_cyc = cycle;
            abort_cut   = 1'b0;
        end
        dcnt++;
        adc_valid = (dcnt % duty == 0);
        if (adc_valid) begin
            x = gen_sample();
            adc_data = x[DW-1:0];
            hist.push_back(x);
            if (hist.size() > 64) void'(hist.pop_front());
        end else begin
            adc_data = DW'($urandom);
        end
    endtask

    task automatic start_sweep();
        writes    = 0;
        exp_addr  = 0;
        pulses    = 0;
        first_lat = -1;
        learn_en  = 1'b1;
        rise_cyc  = cycle;
    endtask

    task automatic run_sweep();
        int n;
        start_sweep();
        n = 0;
        while (!learn_done && n < 2000) begin
            step();
            n++;
        end
        chk("learn_done", int'(learn_done), 1);
        chk("write_count", writes, N_STEPS);
        chk("pulse_count", pulses, N_STEPS - 1);
        chk("busy_in_done", int'(learn_busy), 0);
        if (duty == 1) begin
            chk("first_write_latency",
                int'(first_lat >= SETTLE_CYC + MEAS_SAMPLES &&
                     first_lat <= SETTLE_CYC + MEAS_SAMPLES + 2), 1);
        end
        repeat (10) step();
        chk("no_extra_write", writes, N_STEPS);
        chk("no_extra_pulse", pulses, N_STEPS - 1);
        learn_en = 1'b0;
        step();
        step();
        chk("done_cleared", int'(learn_done), 0);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        learn_en  = 1'b0;
        adc_valid = 1'b0;
        adc_data  = '0;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_next_freq", int'(next_freq), 0);
        chk("rst_amp_we", int'(amp_we), 0);
        chk("rst_amp_addr", int'(amp_addr), 0);
        chk("rst_amp_data", int'(amp_data), 0);
        chk("rst_busy", int'(learn_busy), 0);
        chk("rst_done", int'(learn_done), 0);

        // Full sweep of a +/-300 sine, valid every cycle.
        mode = 1; duty = 1;
        run_sweep();
`ifdef AMP_MEAN_ABS_EN
        chk("sine_amp", last_data, 188);
`else
        chk("sine_amp", last_data, 600);
`endif

        // Full-scale extremes, then silence.
        mode = 2;
        run_sweep();
`ifdef AMP_MEAN_ABS_EN
        chk("extreme_amp", last_data, 511);
`else
        chk("extreme_amp", last_data, 1023);
`endif
        mode = 3; const_val = 0;
        run_sweep();
        chk("zero_amp", last_data, 0);

        // Random data with valid on one cycle in three.
        mode = 0; duty = 3;
        run_sweep();
        duty = 1;

        // Abort while stepping after the write of index 2, then restart from index 0.
        mode = 0;
        start_sweep();
        n = 0;
        while (!(writes == 3 && next_freq) && n < 2000) begin
            step();
            n++;
        end
        chk("reached_step_idx2", int'(writes == 3 && next_freq), 1);
        abort_cut = 1'b1;
        learn_en  = 1'b0;
        step();
        chk("abort_next_freq", int'(next_freq), 0);
        chk("abort_busy", int'(learn_busy), 0);
        repeat (60) step();
        chk("abort_no_write", writes, 3);
        run_sweep();

        // Reset in the middle of a measurement window with learn_en held high.
        start_sweep();
        repeat (SETTLE_CYC + 6) step();
        chk("pre_reset_busy", int'(learn_busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_next_freq", int'(next_freq), 0);
        chk("midrst_amp_we", int'(amp_we), 0);
        chk("midrst_amp_addr", int'(amp_addr), 0);
        chk("midrst_amp_data", int'(amp_data), 0);
        chk("midrst_busy", int'(learn_busy), 0);
        chk("midrst_done", int'(learn_done), 0);
        repeat (60) step();
        chk("held_level_no_write", writes, 0);
        chk("held_level_idle", int'(learn_busy), 0);
        learn_en = 1'b0;
        step();
        run_sweep();

        // Symmetric square wave and the most negative constant.
        mode = 4;
        run_sweep();
`ifdef AMP_MEAN_ABS_EN
        chk("square_amp", last_data, 100);
`else
        chk("square_amp", last_data, 200);
`endif
        mode = 3; const_val = -512;
        run_sweep();
`ifdef AMP_MEAN_ABS_EN
        chk("neg_full_amp", last_data, 511);
`else
        chk("neg_full_amp", last_data, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
